demo_burst_seq: RTL and testbench

- Parametrised burst sequencer that drives one bus master port (valid/ready/rw_mode/addr/wdata/rdata) from a local scratch RAM.
- A falling edge on a push-button start launches a burst of N single transfers.
- Write bursts stream RAM → slave. Read bursts store slave data into RAM.
- Adds burst length, address stride, a master-handshake timeout with error flag, and a host port to preload/inspect the scratch RAM.

---
 rtl/demo_burst_seq_pkg.sv | 24 ++
 rtl/demo_burst_seq_if.sv | 24 ++
 rtl/demo_burst_seq_scratch_ram.sv | 23 ++
 rtl/demo_burst_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_demo_burst_seq.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/demo_burst_seq_pkg.sv
// Shared types and defaults for the burst sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demo_seq_pkg;

  // Sequencer control states; FETCH and STORE are visited only by write and read bursts respectively.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_ACC  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_STORE     = 3'd5,
    ST_NEXT      = 3'd6
  } seq_state_t;

  // Conventional base of the slave window used by bring-up bursts.
  localparam logic [15:0] DEF_BASE_ADDR = 16'h8800;
  // Read bursts land this many RAM words above the write-burst source area.
  localparam int          DEF_RD_OFFSET = 5;
  // Cycles allowed per master handshake phase before giving up.
  localparam int          DEF_TIMEOUT   = 1024;

endpackage

// File: rtl/demo_burst_seq_if.sv
// Single-transfer master bus: one-cycle valid strobe, m_ready low = accepted, high again = done.
// Latency: wires only.
// Backpressure: slave holds m_ready high (idle) / low (busy); master waits on it per phase.
interface demo_burst_seq_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic                  m_valid;
  logic                  m_rw_mode;
  logic                  m_ready;

  modport master (
    output m_addr, m_wdata, m_valid, m_rw_mode,
    input  m_rdata, m_ready
  );

  modport slave (
    input  m_addr, m_wdata, m_valid, m_rw_mode,
    output m_rdata, m_ready
  );
endinterface

// File: rtl/demo_burst_seq_scratch_ram.sv
// Single-port scratch RAM, DATA_WIDTH x 2^MEM_ADDR_WIDTH, contents not reset.
// Latency: write takes effect at the clock edge; read data q appears 1 cycle after addr.
// Backpressure: none, always accepts.
module seq_scratch_ram #(
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [MEM_ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH-1:0]     q
);
  logic [DATA_WIDTH-1:0] mem [2**MEM_ADDR_WIDTH];

  // Registered read (old data on a same-address write) plus optional write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    q <= mem[addr];
  end
endmodule

// File: rtl/demo_burst_seq.sv
// Burst sequencer: button falling edge launches N single transfers between scratch RAM and a master bus.
// Latency: write transfer = 2 fetch + issue + handshake + next; read = issue + handshake + store + next.
// Backpressure: each handshake phase waits on m_ready, bounded by TIMEOUT cycles (then err_timeout, abort).
module demo_burst_seq
  import demo_seq_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_ADDR_WIDTH = 5,
  parameter int LEN_WIDTH      = 4,
  parameter int RD_OFFSET      = DEF_RD_OFFSET,
  parameter int TIMEOUT        = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic                      mode,
  input  logic [LEN_WIDTH-1:0]      burst_len,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [ADDR_WIDTH-1:0]     stride,
  output logic                      ready,
  output logic                      err_timeout,
  output logic [LEN_WIDTH-1:0]      xfer_count,
  output logic [DATA_WIDTH-1:0]     last_rdata,
  demo_burst_seq_if.master          m_bus,
  input  logic                      host_we,
  input  logic [MEM_ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0]     host_wdata,
  output logic [DATA_WIDTH-1:0]     host_rdata
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  seq_state_t state;
  seq_state_t state_nxt;

  logic                      start_prev;
  logic                      trig;
  logic                      accept;
  logic                      last_xfer;
  logic                      tmo_hit;
  logic                      fetch_ph;
  logic [TMO_W-1:0]          tmo_cnt;
  logic [LEN_WIDTH-1:0]      idx;
  logic [LEN_WIDTH-1:0]      len_q;
  logic [ADDR_WIDTH-1:0]     stride_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic                      valid_q;
  logic                      rw_mode_q;

  logic                      ram_we;
  logic [MEM_ADDR_WIDTH-1:0] ram_addr;
  logic [MEM_ADDR_WIDTH-1:0] seq_ram_addr;
  logic [DATA_WIDTH-1:0]     ram_wdata;
  logic [DATA_WIDTH-1:0]     ram_q;

  // A button press is a high-to-low transition of the active-low start input.
  assign trig      = start_prev & ~start;
  assign accept    = (state == ST_IDLE) && trig && (burst_len != '0);
  assign last_xfer = (idx == len_q - LEN_WIDTH'(1));
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT - 1));

  // Write bursts source RAM[idx]; read bursts land at RAM[idx + RD_OFFSET], both wrapping at RAM depth.
  assign seq_ram_addr = rw_mode_q ? MEM_ADDR_WIDTH'(idx)
                                  : MEM_ADDR_WIDTH'(idx) + MEM_ADDR_WIDTH'(RD_OFFSET);

  assign m_bus.m_addr    = addr_q;
  assign m_bus.m_wdata   = wdata_q;
  assign m_bus.m_valid   = valid_q;
  assign m_bus.m_rw_mode = rw_mode_q;
  assign host_rdata      = ram_q;

  seq_scratch_ram #(
    .DATA_WIDTH     (DATA_WIDTH),
    .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // State register; reset forces IDLE on the next edge even mid-handshake.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: walk one transfer at a time, abort to IDLE when a handshake phase times out.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = mode ? ST_FETCH : ST_ISSUE;
        end
      end
      ST_FETCH: begin
        if (fetch_ph) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_nxt = ST_WAIT_ACC;
      end
      ST_WAIT_ACC: begin
        if (!m_bus.m_ready) begin
          state_nxt = ST_WAIT_DONE;
        end else if (tmo_hit) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (m_bus.m_ready) begin
          state_nxt = rw_mode_q ? ST_NEXT : ST_STORE;
        end else if (tmo_hit) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_STORE: begin
        state_nxt = ST_NEXT;
      end
      ST_NEXT: begin
        if (last_xfer) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = rw_mode_q ? ST_FETCH : ST_ISSUE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs: host owns the RAM port in IDLE; otherwise the sequencer does and writes only in STORE.
  always_comb begin
    ready     = (state == ST_IDLE);
    ram_we    = 1'b0;
    ram_addr  = seq_ram_addr;
    ram_wdata = m_bus.m_rdata;
    if (state == ST_IDLE) begin
      ram_we    = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end else if (state == ST_STORE) begin
      ram_we    = 1'b1;
    end
  end

  // Datapath: burst parameters, address/data staging, counters and status flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      start_prev  <= 1'b1;
      valid_q     <= 1'b0;
      rw_mode_q   <= 1'b0;
      err_timeout <= 1'b0;
      xfer_count  <= '0;
      last_rdata  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      idx         <= '0;
      len_q       <= '0;
      stride_q    <= '0;
      fetch_ph    <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      start_prev <= start;
      // Strobe exactly while the FSM sits in ISSUE.
      valid_q    <= (state_nxt == ST_ISSUE);
      fetch_ph   <= (state == ST_FETCH) ? ~fetch_ph : 1'b0;

      // Restart the phase timer on every state change so each wait phase gets a full budget.
      if (state_nxt != state) begin
        tmo_cnt <= '0;
      end else if (state == ST_WAIT_ACC || state == ST_WAIT_DONE) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            rw_mode_q   <= mode;
            len_q       <= burst_len;
            stride_q    <= stride;
            addr_q      <= base_addr;
            err_timeout <= 1'b0;
            xfer_count  <= '0;
            idx         <= '0;
          end
        end
        ST_FETCH: begin
          // Second fetch cycle: RAM q now holds the word addressed in the first.
          if (fetch_ph) begin
            wdata_q <= ram_q;
          end
        end
        ST_WAIT_ACC: begin
          if (m_bus.m_ready && tmo_hit) begin
            err_timeout <= 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!m_bus.m_ready && tmo_hit) begin
            err_timeout <= 1'b1;
          end
        end
        ST_STORE: begin
          last_rdata <= m_bus.m_rdata;
        end
        ST_NEXT: begin
          xfer_count <= xfer_count + LEN_WIDTH'(1);
          // Address advances incrementally, giving base + idx*stride with natural wrap.
          if (!last_xfer) begin
            idx    <= idx + LEN_WIDTH'(1);
            addr_q <= addr_q + stride_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demo_burst_seq.sv
module tb_demo_burst_seq;
  import demo_seq_pkg::*;

  localparam int TB_LEN_W   = 5;
  localparam int TB_RD_OFS  = 5;
  localparam int TB_TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        mode;
  logic [TB_LEN_W-1:0] burst_len;
  logic [15:0] base_addr;
  logic [15:0] stride;
  logic        ready;
  logic        err_timeout;
  logic [TB_LEN_W-1:0] xfer_count;
  logic [7:0]  last_rdata;
  logic        host_we;
  logic [4:0]  host_addr;
  logic [7:0]  host_wdata;
  logic [7:0]  host_rdata;

  int n_chk  = 0;
  int n_pass = 0;
  int n_issue = 0;
  int slave_mode = 0;  // 0 normal, 1 never accepts, 2 holds busy until released

  logic [15:0] exp_addr [$];
  logic [7:0]  exp_wd   [$];
  logic        exp_rw   [$];
  logic [7:0]  rd_q     [$];

  demo_burst_seq_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

  demo_burst_seq #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .MEM_ADDR_WIDTH(5), .LEN_WIDTH(TB_LEN_W),
    .RD_OFFSET(TB_RD_OFS), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .mode(mode), .burst_len(burst_len),
    .base_addr(base_addr), .stride(stride), .ready(ready), .err_timeout(err_timeout),
    .xfer_count(xfer_count), .last_rdata(last_rdata), .m_bus(bus),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic sb_push(input logic [15:0] a, input logic [7:0] wd, input logic rw);
    exp_addr.push_back(a);
    exp_wd.push_back(wd);
    exp_rw.push_back(rw);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
  endtask

  task automatic run_burst(input logic m, input logic [TB_LEN_W-1:0] len,
                           input logic [15:0] base, input logic [15:0] str);
    mode = m; burst_len = len; base_addr = base; stride = str;
    pulse_start();
  endtask

  task automatic wait_idle(input string tag, input int max_cyc, output int n);
    n = 0;
    @(negedge clk);
    while (!ready && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, ready, 1);
  endtask

  task automatic host_wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk); host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk); host_we = 1'b0;
  endtask

  task automatic host_rd(input logic [4:0] a, output logic [7:0] d);
    @(negedge clk); host_we = 1'b0; host_addr = a;
    @(negedge clk); d = host_rdata;
  endtask

  // Slave model: checks each strobe against the scoreboard, then performs the accept/done handshake.
  initial begin
    logic [15:0] ea;
    logic [7:0]  ew;
    logic        er;
    bus.m_ready = 1'b1;
    bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.m_valid) begin
        n_issue++;
        er = 1'b0;
        if (exp_addr.size() == 0) begin
          chk("sb_underflow_valid", bus.m_valid, 0);
        end else begin
          ea = exp_addr.pop_front();
          ew = exp_wd.pop_front();
          er = exp_rw.pop_front();
          chk("m_addr", bus.m_addr, ea);
          chk("m_rw_mode", bus.m_rw_mode, er);
          if (er) chk("m_wdata", bus.m_wdata, ew);
        end
        if (slave_mode != 1) begin
          bus.m_ready = 1'b0;
          repeat (2) @(negedge clk);
          while (slave_mode == 2) @(negedge clk);
          if (!er && rd_q.size() > 0) bus.m_rdata = rd_q.pop_front();
          bus.m_ready = 1'b1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    chk("watchdog_expired", 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pre [4];
    logic [7:0] d;
    int n;
    int iss0;
    pre = '{8'hA5, 8'h5A, 8'hC3, 8'h3C};
    rstn = 1'b0; start = 1'b1; mode = 1'b0; burst_len = '0; base_addr = '0; stride = '0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ready", ready, 1);
    chk("rst_err", err_timeout, 0);
    chk("rst_xfer", xfer_count, 0);
    chk("rst_last_rdata", last_rdata, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_wdata", bus.m_wdata, 0);
    chk("rst_m_rw_mode", bus.m_rw_mode, 0);
    rstn = 1'b1;

    // Preload and a quick readback through the host port
    for (int i = 0; i < 4; i++) host_wr(5'(i), pre[i]);
    host_rd(5'd2, d);
    chk("host_rd2", d, 8'hC3);

    // Write burst: RAM[0..3] to 8801h..8804h
    iss0 = n_issue;
    for (int i = 0; i < 4; i++) sb_push(16'h8801 + 16'(i), pre[i], 1'b1);
    run_burst(1'b1, 5'd4, 16'h8801, 16'd1);
    chk("wr_busy", ready, 0);
    wait_idle("wr_done", 200, n);
    chk("wr_xfer", xfer_count, 4);
    chk("wr_issues", n_issue - iss0, 4);
    chk("wr_sb_drain", exp_addr.size(), 0);

    // Read burst: stride 2, data lands at RAM[5..7]
    for (int i = 0; i < 3; i++) begin
      sb_push(DEF_BASE_ADDR + 16'(2 * i), 8'h00, 1'b0);
      rd_q.push_back(8'h11 * 8'(i + 1));
    end
    run_burst(1'b0, 5'd3, DEF_BASE_ADDR, 16'd2);
    wait_idle("rd_done", 200, n);
    chk("rd_xfer", xfer_count, 3);
    chk("rd_last_rdata", last_rdata, 8'h33);
    for (int i = 0; i < 3; i++) begin
      host_rd(5'(TB_RD_OFS + i), d);
      chk("rd_ram", d, 8'h11 * 8'(i + 1));
    end
    chk("rd_sb_drain", exp_addr.size(), 0);

    // Bus address wraps past FFFFh
    sb_push(16'hFFFF, 8'hA5, 1'b1);
    sb_push(16'h0000, 8'h5A, 1'b1);
    run_burst(1'b1, 5'd2, 16'hFFFF, 16'd1);
    wait_idle("wrap_done", 200, n);
    chk("wrap_xfer", xfer_count, 2);
    chk("wrap_sb_drain", exp_addr.size(), 0);

    // Second press while busy must be ignored
    iss0 = n_issue;
    sb_push(16'h4000, 8'hA5, 1'b1);
    sb_push(16'h4003, 8'h5A, 1'b1);
    run_burst(1'b1, 5'd2, 16'h4000, 16'd3);
    run_burst(1'b0, 5'd7, 16'h7777, 16'd1);
    wait_idle("busy_done", 200, n);
    repeat (10) @(negedge clk);
    chk("busy_ready", ready, 1);
    chk("busy_xfer", xfer_count, 2);
    chk("busy_issues", n_issue - iss0, 2);

    // Zero length press is ignored
    iss0 = n_issue;
    run_burst(1'b1, 5'd0, 16'h5000, 16'd1);
    repeat (3) @(negedge clk);
    chk("len0_ready", ready, 1);
    chk("len0_issues", n_issue - iss0, 0);
    chk("len0_xfer", xfer_count, 2);

    // Timeout: slave never accepts
    slave_mode = 1;
    iss0 = n_issue;
    sb_push(16'h2000, 8'h00, 1'b0);
    run_burst(1'b0, 5'd2, 16'h2000, 16'd1);
    wait_idle("tmo_done", TB_TIMEOUT + 100, n);
    chk("tmo_cycles", n, TB_TIMEOUT);
    chk("tmo_err", err_timeout, 1);
    chk("tmo_xfer", xfer_count, 0);
    chk("tmo_issues", n_issue - iss0, 1);
    slave_mode = 0;
    repeat (2) @(negedge clk);
    chk("tmo_err_sticky", err_timeout, 1);
    sb_push(16'h2100, 8'hA5, 1'b1);
    run_burst(1'b1, 5'd1, 16'h2100, 16'd1);
    chk("tmo_err_cleared", err_timeout, 0);
    wait_idle("tmo_next_done", 200, n);
    chk("tmo_next_xfer", xfer_count, 1);
    chk("tmo_next_err", err_timeout, 0);

    // Reset while waiting for completion
    slave_mode = 2;
    sb_push(16'h1234, 8'h00, 1'b0);
    run_burst(1'b0, 5'd3, 16'h1234, 16'd4);
    repeat (3) @(negedge clk);
    chk("mid_busy", ready, 0);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_m_valid", bus.m_valid, 0);
    chk("mid_ready", ready, 1);
    chk("mid_xfer", xfer_count, 0);
    rstn = 1'b1;
    slave_mode = 0;
    repeat (5) @(negedge clk);
    chk("mid_sb_drain", exp_addr.size(), 0);
    for (int i = 0; i < 3; i++) begin
      host_rd(5'(TB_RD_OFS + i), d);
      chk("mid_ram_kept", d, 8'h11 * 8'(i + 1));
    end
    host_rd(5'd3, d);
    chk("mid_ram3_kept", d, 8'h3C);

    // Long read burst: store address wraps past the top of RAM
    for (int i = 0; i < 30; i++) begin
      sb_push(16'(i), 8'h00, 1'b0);
      rd_q.push_back(8'h40 + 8'(i));
    end
    run_burst(1'b0, 5'd30, 16'h0000, 16'd1);
    wait_idle("ramwrap_done", 1500, n);
    chk("ramwrap_xfer", xfer_count, 30);
    chk("ramwrap_last", last_rdata, 8'h5D);
    host_rd(5'd31, d);
    chk("ramwrap_31", d, 8'h5A);
    for (int i = 0; i < 3; i++) begin
      host_rd(5'(i), d);
      chk("ramwrap_low", d, 8'h5B + 8'(i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
